data_mem_ctrl: RTL and testbench

Parametrised data-memory controller for the ucpu datapath. It generalises the single-purpose register-file data interface with configurable depth and width, an op field (NOP/READ/WRITE/SWAP), out-of-range detection, and an optional clear-on-reset sweep.
- Accesses are sequenced by the control unit's DECODE/EXECUTE1/EXECUTE2 state.
- Read data is returned with a one-cycle valid strobe.

---
 rtl/ucpu_mem_pkg.sv | 21 ++
 rtl/data_mem_array.sv | 37 +++
 rtl/data_mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ucpu_mem_pkg.sv
// Shared types and constants for the ucpu data-memory controller.
package ucpu_mem_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_SWAP  = 2'd3
    } mem_op_e;

    // Default control-unit state encodings
    localparam int unsigned CS_DECODE   = 0;
    localparam int unsigned CS_EXECUTE1 = 1;
    localparam int unsigned CS_EXECUTE2 = 2;

    // Controller FSM states
    typedef logic ctrl_state_t;
    localparam ctrl_state_t ST_CLEAR = 1'b0;
    localparam ctrl_state_t ST_IDLE  = 1'b1;

endpackage

// File: rtl/data_mem_array.sv
// Word array with one synchronous write port and one combinational read port.
module data_mem_array #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  sys_clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic                  wr_in_range;
    logic                  rd_in_range;

    assign wr_idx      = wr_addr[IDX_WIDTH-1:0];
    assign rd_idx      = rd_addr[IDX_WIDTH-1:0];
    assign wr_in_range = 32'(wr_addr) < DEPTH;
    assign rd_in_range = 32'(rd_addr) < DEPTH;

    always_ff @(posedge sys_clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Addresses past DEPTH (non-power-of-two depth) read as zero
    assign rd_data = rd_in_range ? mem[rd_idx] : '0;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: two-phase (EXECUTE1 latch, EXECUTE2 execute) access with clear sweep.
module data_mem_ctrl
    import ucpu_mem_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned CONTROL_STATES = 3,
    parameter int unsigned DECODE         = CS_DECODE,
    parameter int unsigned EXECUTE1       = CS_EXECUTE1,
    parameter int unsigned EXECUTE2       = CS_EXECUTE2,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    localparam int unsigned CS_WIDTH = (CONTROL_STATES > 1) ? $clog2(CONTROL_STATES) : 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset,
    input  logic [CS_WIDTH-1:0]   control_state,
    input  logic                  mem_en,
    input  logic [1:0]            mem_op,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_rd_valid,
    output logic                  mem_ready,
    output logic                  mem_err
);

    ctrl_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q;
    logic                  pending_q;
    mem_op_e               op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  err_q;
    logic                  ready_q;

    logic                  is_decode, is_exec1, is_exec2;
    logic                  in_range, do_exec, op_reads, op_writes, clear_last;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_waddr;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic [DATA_WIDTH-1:0] arr_rdata;

    assign is_decode  = control_state == CS_WIDTH'(DECODE);
    assign is_exec1   = control_state == CS_WIDTH'(EXECUTE1);
    assign is_exec2   = control_state == CS_WIDTH'(EXECUTE2);
    assign in_range   = 32'(addr_q) < DEPTH;
    assign do_exec    = is_exec2 && pending_q && mem_en;
    assign op_reads   = (op_q == OP_READ) || (op_q == OP_SWAP);
    assign op_writes  = (op_q == OP_WRITE) || (op_q == OP_SWAP);
    assign clear_last = 32'(clr_ptr_q) == (DEPTH - 1);

    always_comb begin
        state_d = state_q;
        if (state_q == ST_CLEAR && clear_last) begin
            state_d = ST_IDLE;
        end
    end

    // The sweep owns the write port while clearing; accesses cannot be pending then
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = addr_q;
        arr_wdata = wdata_q;
        if (!sys_reset) begin
            if (state_q == ST_CLEAR) begin
                arr_we    = 1'b1;
                arr_waddr = clr_ptr_q;
                arr_wdata = '0;
            end else if (do_exec && op_writes && in_range) begin
                arr_we = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_ptr_q  <= '0;
            pending_q  <= 1'b0;
            op_q       <= OP_NOP;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= state_d == ST_IDLE;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            if (state_q == ST_CLEAR) begin
                clr_ptr_q <= clr_ptr_q + ADDR_WIDTH'(1);
            end
            if (is_exec1 && mem_en) begin
                if (ready_q) begin
                    pending_q <= 1'b1;
                    op_q      <= mem_op_e'(mem_op);
                    addr_q    <= mem_addr;
                    wdata_q   <= mem_wr_data;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (do_exec) begin
                pending_q <= 1'b0;
                if (op_q != OP_NOP && !in_range) begin
                    err_q <= 1'b1;
                end
                // Array write lands on this same edge, so SWAP returns the old word
                if (op_reads) begin
                    rd_data_q  <= in_range ? arr_rdata : '0;
                    rd_valid_q <= 1'b1;
                end
            end else if (is_decode || is_exec2) begin
                pending_q <= 1'b0;
            end
        end
    end

    data_mem_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .sys_clk (sys_clk),
        .wr_en   (arr_we),
        .wr_addr (arr_waddr),
        .wr_data (arr_wdata),
        .rd_addr (addr_q),
        .rd_data (arr_rdata)
    );

    assign mem_rd_data  = rd_data_q;
    assign mem_rd_valid = rd_valid_q;
    assign mem_ready    = ready_q;
    assign mem_err      = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: transaction-level model plus literal spot checks.
module tb_data_mem_ctrl;

    localparam int DEPTH = 16;
    localparam logic [1:0] DEC = 2'd0, EX1 = 2'd1, EX2 = 2'd2;
    localparam logic [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2, SW = 2'd3;

    logic       sys_clk = 1'b0;
    logic       sys_reset = 1'b1;
    logic [1:0] control_state = DEC;
    logic       mem_en = 1'b0;
    logic [1:0] mem_op = NOP;
    logic [4:0] mem_addr = '0;
    logic [7:0] mem_wr_data = '0;
    logic [7:0] mem_rd_data;
    logic       mem_rd_valid;
    logic       mem_ready;
    logic       mem_err;

    data_mem_ctrl dut (
        .sys_clk       (sys_clk),
        .sys_reset     (sys_reset),
        .control_state (control_state),
        .mem_en        (mem_en),
        .mem_op        (mem_op),
        .mem_addr      (mem_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_rd_data   (mem_rd_data),
        .mem_rd_valid  (mem_rd_valid),
        .mem_ready     (mem_ready),
        .mem_err       (mem_err)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Model state: memory contents and what the outputs must show this cycle
    logic [7:0] exp_mem [32];
    logic [7:0] exp_rd_data;
    logic       exp_valid, exp_err, exp_ready;
    bit         check_en = 1'b0;
    int         since_rel = 0;
    int         valid_cnt = 0;
    int         err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (check_en) begin
            check("rd_data", 32'(mem_rd_data), 32'(exp_rd_data));
            check("rd_valid", 32'(mem_rd_valid), 32'(exp_valid));
            check("err", 32'(mem_err), 32'(exp_err));
            check("ready", 32'(mem_ready), 32'(exp_ready));
            if (mem_rd_valid === 1'b1) valid_cnt++;
            if (mem_err === 1'b1) err_cnt++;
        end
    end

    task automatic cycle();
        @(posedge sys_clk);
        #1;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (sys_reset) begin
            since_rel   = 0;
            exp_rd_data = '0;
            exp_ready   = 1'b0;
            check_en    = 1'b1;
            for (int i = 0; i < 32; i++) exp_mem[i] = '0;
        end else begin
            since_rel++;
            exp_ready = since_rel >= DEPTH;
        end
    endtask

    // mode 0: normal, 1: mem_en low in EXECUTE2, 2: DECODE between EXECUTE1 and EXECUTE2
    task automatic access(input logic [1:0] op, input logic [4:0] addr, input logic [7:0] data,
                          input int mode);
        bit acc;
        bit inr;
        acc           = exp_ready;
        control_state = EX1;
        mem_en        = 1'b1;
        mem_op        = op;
        mem_addr      = addr;
        mem_wr_data   = data;
        cycle();
        if (!acc) exp_err = 1'b1;
        if (mode == 2) begin
            control_state = DEC;
            mem_en        = 1'b0;
            cycle();
        end
        // Scramble the buses so only the latched values can be used
        control_state = EX2;
        mem_en        = (mode != 1);
        mem_op        = ~op;
        mem_addr      = ~addr;
        mem_wr_data   = ~data;
        cycle();
        if (acc && mode == 0) begin
            inr = int'(addr) < DEPTH;
            if (op != NOP && !inr) exp_err = 1'b1;
            if (op == RD || op == SW) begin
                exp_rd_data = inr ? exp_mem[addr] : 8'h00;
                exp_valid   = 1'b1;
            end
            if ((op == WR || op == SW) && inr) exp_mem[addr] = data;
        end
        control_state = DEC;
        mem_en        = 1'b0;
        cycle();
    endtask

    initial begin
        int v0, e0;

        // Power-on reset and full sweep timing
        cycle();
        cycle();
        sys_reset = 1'b0;
        for (int i = 0; i < 15; i++) cycle();
        check("ready_low_15", 32'(mem_ready), 32'd0);
        cycle();
        check("ready_high_16", 32'(mem_ready), 32'd1);

        for (int a = 0; a < DEPTH; a++) access(RD, 5'(a), 8'h00, 0);
        check("cleared_word15", 32'(mem_rd_data), 32'h00);

        // Write then read back, valid pulses exactly once
        access(WR, 5'd3, 8'hA5, 0);
        v0 = valid_cnt;
        access(RD, 5'd3, 8'h00, 0);
        check("read3_a5", 32'(mem_rd_data), 32'hA5);
        check("read3_one_valid", 32'(valid_cnt - v0), 32'd1);

        // Atomic swap returns old word
        access(SW, 5'd3, 8'h5A, 0);
        check("swap3_old", 32'(mem_rd_data), 32'hA5);
        access(RD, 5'd3, 8'h00, 0);
        check("read3_5a", 32'(mem_rd_data), 32'h5A);

        // Out-of-range accesses
        e0 = err_cnt;
        access(WR, 5'd20, 8'hFF, 0);
        check("oor_write_err", 32'(err_cnt - e0), 32'd1);
        access(WR, 5'd16, 8'hEE, 0);
        e0 = err_cnt;
        v0 = valid_cnt;
        access(RD, 5'd20, 8'h00, 0);
        check("oor_read_zero", 32'(mem_rd_data), 32'h00);
        check("oor_read_valid", 32'(valid_cnt - v0), 32'd1);
        check("oor_read_err", 32'(err_cnt - e0), 32'd1);
        e0 = err_cnt;
        access(NOP, 5'd25, 8'h11, 0);
        access(NOP, 5'd2, 8'h11, 0);
        check("nop_no_err", 32'(err_cnt - e0), 32'd0);
        access(WR, 5'd15, 8'h3C, 0);
        for (int a = 0; a < DEPTH; a++) access(RD, 5'(a), 8'h00, 0);
        check("last_word_3c", 32'(mem_rd_data), 32'h3C);

        // Aborted accesses leave no trace
        e0 = err_cnt;
        v0 = valid_cnt;
        access(WR, 5'd4, 8'h77, 1);
        access(WR, 5'd4, 8'h66, 2);
        access(RD, 5'd4, 8'h00, 2);
        check("abort_no_pulses", 32'(err_cnt - e0 + valid_cnt - v0), 32'd0);
        access(RD, 5'd4, 8'h00, 0);
        check("addr4_unchanged", 32'(mem_rd_data), 32'h00);

        // Reset in the middle of the sweep restarts it
        access(WR, 5'd10, 8'h44, 0);
        sys_reset = 1'b1;
        cycle();
        sys_reset = 1'b0;
        for (int i = 0; i < 7; i++) cycle();
        sys_reset = 1'b1;
        cycle();
        sys_reset = 1'b0;
        e0 = err_cnt;
        access(WR, 5'd5, 8'h33, 0);
        check("clear_access_err", 32'(err_cnt - e0), 32'd1);
        for (int i = 0; i < 64 && since_rel < 15; i++) cycle();
        check("resweep_ready_low", 32'(mem_ready), 32'd0);
        cycle();
        check("resweep_ready_high", 32'(mem_ready), 32'd1);
        access(RD, 5'd10, 8'h00, 0);
        check("addr10_recleared", 32'(mem_rd_data), 32'h00);
        access(SW, 5'd5, 8'h99, 0);
        check("addr5_untouched", 32'(mem_rd_data), 32'h00);
        access(RD, 5'd5, 8'h00, 0);
        check("addr5_swapped", 32'(mem_rd_data), 32'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
